// File: rtl/joycon_pkg.sv
// rtl/joycon_pkg.sv - shared pad reader state encoding and button bit positions
package joycon_pkg;

  localparam int NUM_BTNS = 8;
  localparam int PHASE_W  = 8;
  localparam int POLL_W   = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_CLK_HI = 3'd4,
    ST_DONE   = 3'd5
  } pad_state_t;

  // Bit order of the 4021 shift chain, shared with the CPU-side shift register
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with parameterised reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/joycon_pad_reader.sv
// rtl/joycon_pad_reader.sv - polls a 4021-based pad and presents an atomic 8-bit button frame
module joycon_pad_reader
  import joycon_pkg::*;
#(
  parameter int CLK_DIV     = 6,
  parameter int POLL_PERIOD = 357954
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pad_data,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [NUM_BTNS-1:0] buttons,
  output logic                frame_valid
);

  localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(CLK_DIV - 1);
  localparam logic [POLL_W-1:0]  POLL_LAST = POLL_W'(POLL_PERIOD - 1);

  pad_state_t          state;
  pad_state_t          state_next;
  logic [POLL_W-1:0]   poll_cnt;
  logic [PHASE_W-1:0]  phase;
  logic                latch_half;
  logic [2:0]          bit_idx;
  logic [NUM_BTNS-1:0] cap;
  logic [NUM_BTNS-1:0] cap_next;
  logic                data_s;
  logic                poll_tc;
  logic                phase_tc;
  logic                latch_nx;
  logic                pclk_nx;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (pad_data),
    .q  (data_s)
  );

  assign poll_tc  = (poll_cnt == POLL_LAST);
  assign phase_tc = (phase == PH_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LATCH spans two phase periods so the 8-bit phase counter covers CLK_DIV up to 255
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (poll_tc) state_next = ST_LATCH;
      ST_LATCH:  if (phase_tc && latch_half) state_next = ST_SETTLE;
      ST_SETTLE: if (phase_tc) state_next = ST_CLK_LO;
      ST_CLK_LO: if (phase_tc) state_next = ST_CLK_HI;
      ST_CLK_HI: if (phase_tc) state_next = (bit_idx == 3'd7) ? ST_DONE : ST_CLK_LO;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_nx    = (state_next == ST_LATCH);
    pclk_nx     = (state_next != ST_CLK_LO);
    frame_valid = (state == ST_DONE);
  end

  always_comb begin
    cap_next = cap;
    if (phase_tc && state == ST_SETTLE) cap_next[BTN_A] = ~data_s;
    if (phase_tc && state == ST_CLK_HI) cap_next[bit_idx] = ~data_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt   <= '0;
      phase      <= '0;
      latch_half <= 1'b0;
      bit_idx    <= 3'd0;
      cap        <= '0;
      buttons    <= '0;
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b1;
    end else begin
      poll_cnt <= poll_tc ? '0 : poll_cnt + POLL_W'(1);

      if (state == ST_IDLE || state_next != state || phase_tc) begin
        phase <= '0;
      end else begin
        phase <= phase + PHASE_W'(1);
      end

      latch_half <= (state == ST_LATCH) && (latch_half || phase_tc);

      if (phase_tc && state == ST_SETTLE) begin
        bit_idx <= 3'd1;
      end else if (phase_tc && state == ST_CLK_HI) begin
        bit_idx <= bit_idx + 3'd1;
      end

      cap <= cap_next;

      // Final bit lands in the same edge, so load from cap_next to keep the frame atomic
      if (state_next == ST_DONE) begin
        buttons <= cap_next;
      end

      pad_latch <= latch_nx;
      pad_clk   <= pclk_nx;
    end
  end

endmodule

// File: tb/tb_joycon_pad_reader.sv
// tb/tb_joycon_pad_reader.sv - randomized self-checking bench with a 4021 pad model
module tb_joycon_pad_reader;

  localparam int CLK_DIV = 3;
  localparam int POLL    = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       frame_valid;

  always #5 clk = ~clk;

  joycon_pad_reader #(
    .CLK_DIV    (CLK_DIV),
    .POLL_PERIOD(POLL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons    (buttons),
    .frame_valid(frame_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pad: parallel load while latch is high, shift towards bit 0 on pad_clk rise, pull-up fills
  logic [7:0] pressed         = 8'h00;
  logic [7:0] sr              = 8'hFF;
  logic [7:0] latched_pressed = 8'h00;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) begin
      sr              <= ~pressed;
      latched_pressed <= pressed;
    end else begin
      sr <= {1'b1, sr[7:1]};
    end
  end

  assign pad_data = sr[0];

  logic [7:0] exp_q[$];
  int         cyc        = 0;
  int         last_fv    = 0;
  bit         has_last   = 1'b0;
  int         latch_cnt  = 0;
  int         rise_cnt   = 0;
  int         fv_total   = 0;
  logic       prev_latch = 1'b0;
  logic       prev_clk   = 1'b1;
  logic [7:0] prev_btn   = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      has_last = 1'b0;
    end else begin
      if (pad_latch && !prev_latch) begin
        exp_q.push_back(latched_pressed);
        latch_cnt = 0;
        rise_cnt  = 0;
      end
      if (pad_latch) latch_cnt++;
      if (pad_clk && !prev_clk) rise_cnt++;
      if (frame_valid) begin
        fv_total++;
        if (exp_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
        else check("frame_buttons", 32'(buttons), 32'(exp_q.pop_front()));
        check("latch_len", latch_cnt, 2 * CLK_DIV);
        check("clk_rises", rise_cnt, 7);
        if (has_last) check("fv_spacing", cyc - last_fv, POLL);
        last_fv  = cyc;
        has_last = 1'b1;
      end else begin
        check("buttons_hold", 32'(buttons), 32'(prev_btn));
      end
    end
    prev_latch = pad_latch;
    prev_clk   = pad_clk;
    prev_btn   = buttons;
  end

  task automatic measure_latch(input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = pad_latch;
    end
    check(tag, n, POLL);
  endtask

  task automatic wait_fv();
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (frame_valid) seen = 1'b1;
    end
    if (!seen) check("fv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_pad_edge(input bit rise, input int n);
    int   cnt = 0;
    int   k   = 0;
    logic p   = pad_clk;
    while (cnt < n && k < 400) begin
      @(negedge clk);
      k++;
      if (rise ? (pad_clk && !p) : (!pad_clk && p)) cnt++;
      p = pad_clk;
    end
    if (cnt < n) check("edge_timeout", 32'd0, 32'd1);
  endtask

  int fv_before;

  initial begin
    rst     = 1'b0;
    pressed = 8'h09;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_padclk", 32'(pad_clk), 32'd1);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    rst = 1'b1;
    measure_latch("first_latch");

    wait_fv();
    check("a_start", 32'(buttons), 32'h09);
    wait_fv();
    pressed = 8'hFF;
    wait_fv();
    check("all_pressed", 32'(buttons), 32'hFF);
    pressed = 8'h00;
    wait_fv();
    check("none_pressed", 32'(buttons), 32'h00);

    pressed = 8'h01;
    wait_fv();
    check("pre_change", 32'(buttons), 32'h01);
    wait_pad_edge(1'b1, 4);
    pressed = 8'h80;
    wait_fv();
    check("mid_change_hold", 32'(buttons), 32'h01);
    wait_fv();
    check("mid_change_next", 32'(buttons), 32'h80);

    pressed = 8'($urandom);
    wait_pad_edge(1'b0, 5);
    #1 rst = 1'b0;
    #1;
    check("abort_latch", 32'(pad_latch), 32'd0);
    check("abort_padclk", 32'(pad_clk), 32'd1);
    check("abort_buttons", 32'(buttons), 32'd0);
    check("abort_fv", 32'(frame_valid), 32'd0);
    fv_before = fv_total;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    measure_latch("relatch");
    check("abort_no_fv", fv_total, fv_before);

    for (int i = 0; i < 50; i++) begin
      pressed = 8'($urandom);
      repeat ($urandom_range(0, 60)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) pressed = 8'($urandom);
      wait_fv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joycon_pad_reader.md
JOYCON_PAD_READER -- requirements
Module: joycon_pad_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6: clk cycles per pad_clk half-period; legal range 3..255.
REQ-002 SHALL have parameter POLL_PERIOD, default 357954: clk cycles from the start of one poll to the start of the next; 24-bit, minimum 20*CLK_DIV.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pad_data, input, 1: serial data from the external 4021 shift register; active-low, asynchronous to clk.
REQ-006 SHALL have port pad_latch, output, 1: parallel-load strobe to the pad; active-high.
REQ-007 SHALL have port pad_clk, output, 1: shift clock to the pad; idles high; pad shifts on its rising edge.
REQ-008 SHALL have port buttons, output, 8: active-high pressed states in bit order 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right; feeds joycon_ctrl_input of the CPU-side shift-register block.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse when buttons is updated.

Function
REQ-010 SHALL synchronise pad_data through two flops before any use; every sample below means the synchronised value.
REQ-011 SHALL implement the FSM IDLE -> LATCH -> SETTLE -> CLK_LO -> CLK_HI -> DONE -> IDLE.
REQ-012 IDLE: a poll counter SHALL count 0..POLL_PERIOD-1 free-running; at terminal count the FSM SHALL enter LATCH and the counter SHALL wrap to 0, keeping the poll rate exact.
REQ-013 LATCH: pad_latch SHALL be 1 for exactly 2*CLK_DIV cycles, then go to SETTLE.
REQ-014 SETTLE: pad_latch SHALL be 0 for CLK_DIV cycles; in the last cycle, inverted data SHALL be stored as bit 0 and the bit index SHALL be set to 1.
REQ-015 CLK_LO: pad_clk SHALL be 0 for CLK_DIV cycles, then go to CLK_HI.
REQ-016 CLK_HI: pad_clk SHALL be 1 for CLK_DIV cycles; in the last cycle, inverted data SHALL be stored at the current bit index.
REQ-017 After CLK_HI the FSM SHALL return to CLK_LO if the index is below 7; otherwise it SHALL go to DONE. The index SHALL increment after each store.
REQ-018 DONE, one cycle: buttons SHALL load all 8 captured bits atomically, frame_valid SHALL be 1, and the FSM SHALL go to IDLE.
REQ-019 buttons SHALL never show a partially shifted frame; it SHALL hold its value between DONE cycles.
REQ-020 A poll SHALL occupy 3*CLK_DIV + 14*CLK_DIV + 1 clk cycles, LATCH start through DONE inclusive.
REQ-021 A single phase counter of 8 bits SHALL time all phases; it SHALL reload to 0 on every state change.
REQ-022 A poll-counter terminal count outside IDLE SHALL be impossible by REQ-002; it needs no handling beyond the continued wrap.
REQ-023 A disconnected pad reads the pull-up (1) on every bit; buttons SHALL be 8'h00.

Reset
REQ-024 While rst is 0: FSM SHALL be IDLE, the poll and phase counters 0, pad_latch 0, pad_clk 1, buttons 8'h00, frame_valid 0, and the sync flops 1.
REQ-025 Reset asserted mid-poll SHALL abort the poll with no buttons update.
REQ-026 After release, the first LATCH SHALL begin POLL_PERIOD cycles later.

Structure
REQ-027 Shared package joycon_pkg SHALL hold the FSM state encoding and the button bit-index constants BTN_A..BTN_RIGHT, which are also used by the CPU-side block.
REQ-028 The synchroniser SHALL be the sub-module sync_2ff, reset value parameterised.
REQ-029 The remainder SHALL be the FSM, the counters and an 8-bit capture register in one module.

Verification
REQ-030 Pad model presses A and Start (bits 0 and 3 driven low), CLK_DIV=3, POLL_PERIOD=100 -> buttons=8'h09 and a single frame_valid pulse.
REQ-031 All eight buttons pressed -> buttons=8'hFF; pad_data held high -> buttons=8'h00.
REQ-032 Timing check, CLK_DIV=3: pad_latch high 6 cycles; 7 rising pad_clk edges per poll; frame_valid spacing exactly 100 cycles.
REQ-033 Pad pattern changed from 8'h01 to 8'h80 while CLK_HI of bit 4 is in progress -> buttons stays 8'h01 until the next DONE, then shows 8'h80, and never a mixed value.
REQ-034 rst pulsed low during CLK_LO of bit 5 -> outputs at reset values immediately, no frame_valid, and the next LATCH 100 cycles after release.
REQ-035 Random pad patterns over 50 polls -> each buttons value equals the bit-inverted pad pattern latched at that poll's LATCH.
